// File: rtl/layer_sched.sv
`default_nettype none
// ============================================================================
//  Module      : layer_sched
//  Description : Convolution layer step scheduler. Walks the nested loop
//                c (ofmap) / t (tile) / b (ifmap) / k (kernel position) for
//                layer C1 or C2 and offers one step per cycle over a
//                valid/ready handshake, flagging accumulator clear (first)
//                and output flush (last) steps.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module layer_sched #(
    parameter int K         = 5,
    parameter int NB_TILE   = 4,
    parameter int NB_IFMAPS = 6,
    parameter int NB_OFMAPS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        layer_sel,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        step_valid,
    input  logic        step_ready,
    output logic [4:0]  k_idx,
    output logic [2:0]  b_idx,
    output logic [3:0]  t_idx,
    output logic [3:0]  c_idx,
    output logic        first,
    output logic        last,
    output logic [13:0] step_cnt
);

    // Loop extents for the two supported layers
    localparam int KK   = K * K;
    localparam int C1_T = NB_TILE * NB_TILE;
    localparam int C1_B = 1;
    localparam int C1_C = 6;
    localparam int C2_T = 4;
    localparam int C2_B = NB_IFMAPS;
    localparam int C2_C = NB_OFMAPS;

    localparam logic [4:0]  K_MAX   = 5'(KK - 1);
    localparam logic [13:0] CNT_MAX = 14'h3FFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Per-layer maximum index values, latched at start
    logic [2:0]  r_b_max;
    logic [3:0]  r_t_max;
    logic [3:0]  r_c_max;

    logic [4:0]  r_k;
    logic [2:0]  r_b;
    logic [3:0]  r_t;
    logic [3:0]  r_c;
    logic [13:0] r_cnt;

    logic        w_run;
    logic        w_xfer;
    logic        w_launch;
    logic        w_k_wrap;
    logic        w_b_wrap;
    logic        w_t_wrap;
    logic        w_c_wrap;
    logic        w_at_end;

    assign w_run    = (r_state == ST_RUN);
    assign w_xfer   = w_run && step_ready;
    assign w_launch = (r_state == ST_IDLE) && start && !abort;
    assign w_k_wrap = (r_k == K_MAX);
    assign w_b_wrap = (r_b == r_b_max);
    assign w_t_wrap = (r_t == r_t_max);
    assign w_c_wrap = (r_c == r_c_max);
    assign w_at_end = w_k_wrap && w_b_wrap && w_t_wrap && w_c_wrap;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort outranks both a transfer and start
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_xfer && w_at_end) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the layer geometry when a layer is launched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_max <= 3'd0;
            r_t_max <= 4'd0;
            r_c_max <= 4'd0;
        end else if (w_launch) begin
            r_b_max <= layer_sel ? 3'(C2_B - 1) : 3'(C1_B - 1);
            r_t_max <= layer_sel ? 4'(C2_T - 1) : 4'(C1_T - 1);
            r_c_max <= layer_sel ? 4'(C2_C - 1) : 4'(C1_C - 1);
        end
    end

    // Nested loop counters, innermost k, advancing only on a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k <= 5'd0;
            r_b <= 3'd0;
            r_t <= 4'd0;
            r_c <= 4'd0;
        end else if (w_launch) begin
            r_k <= 5'd0;
            r_b <= 3'd0;
            r_t <= 4'd0;
            r_c <= 4'd0;
        end else if (w_xfer && !abort) begin
            r_k <= w_k_wrap ? 5'd0 : r_k + 5'd1;
            if (w_k_wrap) begin
                r_b <= w_b_wrap ? 3'd0 : r_b + 3'd1;
                if (w_b_wrap) begin
                    r_t <= w_t_wrap ? 4'd0 : r_t + 4'd1;
                    if (w_t_wrap) begin
                        r_c <= w_c_wrap ? 4'd0 : r_c + 4'd1;
                    end
                end
            end
        end
    end

    // Accepted-step counter, saturating, held between layers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 14'd0;
        end else if (w_launch) begin
            r_cnt <= 14'd0;
        end else if (w_xfer && !abort && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 14'd1;
        end
    end

    // Outputs depend only on registered state, never on step_ready
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign step_valid = w_run;
    assign k_idx      = r_k;
    assign b_idx      = r_b;
    assign t_idx      = r_t;
    assign c_idx      = r_c;
    assign first      = w_run && (r_k == 5'd0) && (r_b == 3'd0);
    assign last       = w_run && w_k_wrap && w_b_wrap;
    assign step_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_layer_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_layer_sched
//  Description : Self-checking bench for layer_sched against a closed-form
//                model of the loop nest (indices derived from the step number).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_layer_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        layer_sel = 1'b0;
    logic        abort = 1'b0;
    logic        step_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        step_valid;
    logic [4:0]  k_idx;
    logic [2:0]  b_idx;
    logic [3:0]  t_idx;
    logic [3:0]  c_idx;
    logic        first;
    logic        last;
    logic [13:0] step_cnt;

    int passed = 0;
    int total  = 0;

    layer_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .layer_sel  (layer_sel),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .k_idx      (k_idx),
        .b_idx      (b_idx),
        .t_idx      (t_idx),
        .c_idx      (c_idx),
        .first      (first),
        .last       (last),
        .step_cnt   (step_cnt)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected step n of a layer: mixed-radix decomposition of n
    function automatic logic [17:0] model(input bit sel, input int n);
        int bb, tt, k, b, t, c;
        bb = sel ? 6 : 1;
        tt = sel ? 4 : 16;
        k  = n % 25;
        b  = (n / 25) % bb;
        t  = (n / (25 * bb)) % tt;
        c  = n / (25 * bb * tt);
        return {5'(k), 3'(b), 4'(t), 4'(c), (k == 0 && b == 0), (k == 24 && b == bb - 1)};
    endfunction

    function automatic logic [17:0] obs_step();
        return {k_idx, b_idx, t_idx, c_idx, first, last};
    endfunction

    // mode 0: run to completion, 1: abort at step stop_at, 2: async reset at step stop_at
    task automatic run_layer(input bit sel, input int pct, input int stall_at,
                             input int mode, input int stop_at);
        int tot, n, cyc, f, l, stalls, budget;
        bit rdy;
        tot = sel ? 9600 : 2400;
        n = 0; cyc = 0; f = 0; l = 0; stalls = 0;
        budget = tot * 4 + 200;
        @(negedge clk);
        start = 1'b1; layer_sel = sel; step_ready = 1'b0;
        while (n < tot) begin
            @(negedge clk);
            start = 1'b0;
            layer_sel = ~sel;
            cyc++;
            if (cyc > budget) begin
                check("timeout", 32'(n), 32'(tot));
                break;
            end
            check("valid", {31'd0, step_valid}, 32'd1);
            check("step", {14'd0, obs_step()}, {14'd0, model(sel, n)});
            if (sel && n == 600)
                check("c_carry", {14'd0, obs_step()}, {14'd0, 5'd0, 3'd0, 4'd0, 4'd1, 1'b1, 1'b0});
            if (mode == 1 && n == stop_at) begin
                abort = 1'b1; step_ready = 1'b1;
                @(negedge clk);
                abort = 1'b0; step_ready = 1'b0;
                check("abort_idle", {29'd0, busy, step_valid, done}, 32'd0);
                check("abort_cnt", {18'd0, step_cnt}, 32'(stop_at));
                @(negedge clk);
                check("abort_nodone", {30'd0, busy, done}, 32'd0);
                return;
            end
            if (mode == 2 && n == stop_at) begin
                step_ready = 1'b1;
                #2 rst_n = 1'b0; start = 1'b1;
                #0.5;
                check("rst_async", {9'd0, busy, done, step_valid, first, last,
                                    k_idx, b_idx, t_idx, c_idx, step_cnt}, 32'd0);
                #0.5 rst_n = 1'b1;
                #1 start = 1'b0;
                @(negedge clk);
                check("rst_idle", {29'd0, busy, step_valid, done}, 32'd0);
                @(negedge clk);
                check("rst_nodone", {30'd0, busy, done}, 32'd0);
                step_ready = 1'b0;
                return;
            end
            if (n == stall_at && stalls < 3) begin
                rdy = 1'b0;
                stalls++;
            end else begin
                rdy = ($urandom_range(99) < pct);
            end
            step_ready = rdy;
            if (rdy) begin
                if (first) f++;
                if (last) l++;
                n++;
            end
        end
        @(negedge clk);
        check("done_pulse", {29'd0, busy, done, step_valid}, 32'b110);
        step_ready = 1'($urandom_range(1));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("back_idle", {30'd0, busy, done}, 32'd0);
        check("cnt_total", {18'd0, step_cnt}, 32'(tot));
        check("firsts", 32'(f), sel ? 32'd64 : 32'd96);
        check("lasts", 32'(l), sel ? 32'd64 : 32'd96);
        if (pct >= 100)
            check("consec", 32'(cyc), 32'(tot + ((stall_at >= 0) ? 3 : 0)));
        @(negedge clk);
        check("cnt_hold", {18'd0, step_cnt}, 32'(tot));
        check("stay_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #3;
        check("reset_state", {9'd0, busy, done, step_valid, first, last,
                              k_idx, b_idx, t_idx, c_idx, step_cnt}, 32'd0);
        #9 rst_n = 1'b1;

        // C1, full-rate handshake with a 3-cycle stall at k=7
        run_layer(1'b0, 100, 7, 0, 0);
        // C1 aborted after 100 transfers, then rerun from the origin
        run_layer(1'b0, 100, -1, 1, 100);
        run_layer(1'b0, 100, -1, 0, 0);
        // C2 with random backpressure
        run_layer(1'b1, 60, -1, 0, 0);

        // start together with abort in IDLE stays idle
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort", {30'd0, busy, step_valid}, 32'd0);

        // asynchronous reset mid-run, then a fresh layer
        run_layer(1'b0, 80, -1, 2, 50);
        run_layer(1'b0, 70, -1, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
